sseg_scan_capture: RTL and testbench
====================================

SSEG_SCAN_CAPTURE -- requirements
Module: sseg_scan_capture

Interface
REQ-001 Parameter SETTLE, default 2: consecutive identical synchronized samples required before a digit is captured; legal range 1..15.
REQ-002 Ports, in order:
  clk  in  1  single system clock, all logic on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  an  in  4  multiplexed anode enables, active-low.
  sseg  in  8  multiplexed segment bus, bit 7 = decimal point.
  dig0..dig3  out  8 each  reconstructed segment byte per digit position.
REQ-003 Further output ports:
  frame_strobe  out  1  one-cycle pulse when dig0..dig3 update.
  frame_valid  out  1  at least one complete in-order frame since reset or last error.
  err_anode  out  1  one-cycle pulse on an illegal anode pattern.
  err_order  out  1  one-cycle pulse on an out-of-sequence digit.
REQ-004 Clocking and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-005 an and sseg SHALL each pass through a 2-flop synchronizer before any use.
REQ-006 Synchronized an SHALL be decoded as follows:
  1110 -> idx 0; 1101 -> idx 1; 1011 -> idx 2; 0111 -> idx 3.
  1111 -> blank.
  Any other value -> illegal.
REQ-007 Dwell counter SHALL reset to 1 whenever synchronized {an,sseg} differs from the previous cycle, increment otherwise, and saturate at SETTLE.
REQ-008 A dwell SHALL be accepted exactly once, on the cycle the counter reaches SETTLE; no further action until {an,sseg} changes.
REQ-009 On an accepted dwell, blank SHALL cause no state change and no pulse.
REQ-010 On an accepted illegal dwell, err_anode SHALL pulse for one cycle, the FSM SHALL go to IDLE, and staging SHALL be left unchanged.
REQ-011 FSM states:
  IDLE (waiting for idx 0).
  SCAN with expected index exp in 1..3.
REQ-012 In IDLE, accepted idx 0 SHALL write stg[0] and go to SCAN with exp=1.
REQ-013 In IDLE, accepted idx 1..3 SHALL be ignored silently.
REQ-014 In SCAN, accepted idx==exp SHALL write stg[idx] and increment exp.
REQ-015 In SCAN, accepted idx==3==exp SHALL complete the frame and return to IDLE.
REQ-016 In SCAN, accepted idx!=exp SHALL pulse err_order and clear frame_valid.
  If idx==0: write stg[0] and restart with exp=1.
  Otherwise: go to IDLE.
REQ-017 On frame completion, dig0..dig3 SHALL load stg[0..2] plus the just-captured idx-3 byte on the next clock edge.
REQ-018 frame_strobe SHALL assert in the same cycle the dig outputs change; frame_valid SHALL set in that same cycle.
REQ-019 dig0..dig3 SHALL change only on frame completion.
REQ-020 Latency from a settled input change to capture SHALL be 2+SETTLE cycles; frame completion to dig update SHALL be 1 cycle.
REQ-021 err_anode and err_order SHALL never be asserted in the same cycle; at most one dwell is accepted per cycle.

Reset
REQ-022 While rst_n is low, the block SHALL hold these values:
  Synchronizer an stages = 4'b1111; sseg stages = 8'hFF.
  Dwell counter = 0; FSM = IDLE.
  stg[0..3] = 8'hFF; dig0..dig3 = 8'hFF.
  frame_strobe, frame_valid, err_anode, err_order = 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; the first acceptance after release SHALL need a full SETTLE dwell.

Structure
REQ-024 The shared display package SHALL hold:
  The four active-low anode codes.
  Blank code 4'b1111.
  Segment-off code 8'hFF.
  The FSM state typedef.
REQ-025 The synchronizer plus dwell counter SHALL be one sub-module, sseg_dwell_filter, outputting synchronized an, synchronized sseg and a one-cycle accept pulse.

Verification
REQ-026 Directed scenarios:
  1. Cycle an 1110/1101/1011/0111 with sseg C0/F9/24/30, 8 clk per digit, SETTLE=2 -> one frame_strobe; dig0..3 = C0,F9,24,30; frame_valid=1.
  2. Insert an=1111 for 8 clk between digits of scenario 1 -> identical result, no error pulses.
  3. Drive an=1100 for 8 clk mid-frame -> single err_anode pulse; dig unchanged; next full frame updates normally.
  4. Order 1110,1011 -> err_order pulse, frame_valid=0, no frame_strobe; a following full in-order frame sets frame_valid=1.
  5. sseg toggles every cycle while an=1110, SETTLE=3 -> no capture until sseg is held for 3 synchronized cycles.
  6. rst_n low for 1 cycle after digit 2 is captured -> all outputs return to reset values; a new frame must start from idx 0.

Source files
------------

// File: rtl/sseg_scan_capture_pkg.sv
// Shared display definitions: anode codes, blank/segment-off codes, FSM state type, anode decoder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package sseg_scan_capture_pkg;

  // Active-low anode enables, one per digit position
  localparam logic [3:0] AN_DIG0  = 4'b1110;
  localparam logic [3:0] AN_DIG1  = 4'b1101;
  localparam logic [3:0] AN_DIG2  = 4'b1011;
  localparam logic [3:0] AN_DIG3  = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  // All segments (and decimal point) dark
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  typedef enum logic [1:0] {
    AN_KIND_DIGIT,
    AN_KIND_BLANK,
    AN_KIND_ILLEGAL
  } an_kind_t;

  typedef struct packed {
    an_kind_t   kind;
    logic [1:0] idx;
  } an_dec_t;

  // Classify an anode pattern; idx is only meaningful for AN_KIND_DIGIT
  function automatic an_dec_t decode_anode(input logic [3:0] an);
    an_dec_t d;
    d.kind = AN_KIND_ILLEGAL;
    d.idx  = 2'd0;
    case (an)
      AN_DIG0:  begin d.kind = AN_KIND_DIGIT; d.idx = 2'd0; end
      AN_DIG1:  begin d.kind = AN_KIND_DIGIT; d.idx = 2'd1; end
      AN_DIG2:  begin d.kind = AN_KIND_DIGIT; d.idx = 2'd2; end
      AN_DIG3:  begin d.kind = AN_KIND_DIGIT; d.idx = 2'd3; end
      AN_BLANK: d.kind = AN_KIND_BLANK;
      default:  d.kind = AN_KIND_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sseg_dwell_filter.sv
// Synchronizes the raw anode/segment bus and accepts a value once it has been stable SETTLE samples.
// Latency: accept pulses 2+SETTLE cycles after a stable change on the pins.
// Backpressure: none; free-running input, accept is a single-cycle pulse per stable dwell.
module sseg_dwell_filter
  import sseg_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] an_sync,
  output logic [7:0] sseg_sync,
  output logic       accept
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [3:0] an_s1, an_s2;
  logic [7:0] sseg_s1, sseg_s2;
  logic [3:0] cnt, cnt_nxt;
  logic       changed;

  // Two-flop synchronizer on both buses; reset to the dark/blank display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1   <= AN_BLANK;
      an_s2   <= AN_BLANK;
      sseg_s1 <= SEG_OFF;
      sseg_s2 <= SEG_OFF;
    end else begin
      an_s1   <= an;
      an_s2   <= an_s1;
      sseg_s1 <= sseg;
      sseg_s2 <= sseg_s1;
    end
  end

  // Dwell count: restart at 1 on any change, otherwise climb and hold at SETTLE
  always_comb begin
    changed = ({an_s2, sseg_s2} != {an_sync, sseg_sync});
    cnt_nxt = cnt;
    if (changed) begin
      cnt_nxt = 4'd1;
    end else if (cnt < SETTLE_C) begin
      cnt_nxt = cnt + 4'd1;
    end
  end

  // Register the tracked value with its count; accept only on the edge the count first hits SETTLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_sync   <= AN_BLANK;
      sseg_sync <= SEG_OFF;
      cnt       <= 4'd0;
      accept    <= 1'b0;
    end else begin
      an_sync   <= an_s2;
      sseg_sync <= sseg_s2;
      cnt       <= cnt_nxt;
      accept    <= (cnt_nxt == SETTLE_C) && (changed || (cnt != SETTLE_C));
    end
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Reconstructs the four digit bytes of a multiplexed 7-segment display scan.
// Latency: dig0..dig3 and frame_strobe update 1 cycle after the digit-3 dwell is accepted.
// Backpressure: none; the scanned display is observed passively and never stalled.
module sseg_scan_capture
  import sseg_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] dig0,
  output logic [7:0] dig1,
  output logic [7:0] dig2,
  output logic [7:0] dig3,
  output logic       frame_strobe,
  output logic       frame_valid,
  output logic       err_anode,
  output logic       err_order
);

  logic [3:0]      an_sync;
  logic [7:0]      sseg_sync;
  logic            accept;
  an_dec_t         dec;

  state_t          state, state_nxt;
  logic [1:0]      exp_idx, exp_nxt;
  logic [3:0][7:0] stg, stg_nxt;
  logic [3:0][7:0] dig_q, dig_nxt;
  logic            strobe_nxt, valid_nxt, err_anode_nxt, err_order_nxt;

  sseg_dwell_filter #(
    .SETTLE (SETTLE)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .an        (an),
    .sseg      (sseg),
    .an_sync   (an_sync),
    .sseg_sync (sseg_sync),
    .accept    (accept)
  );

  assign dig0 = dig_q[0];
  assign dig1 = dig_q[1];
  assign dig2 = dig_q[2];
  assign dig3 = dig_q[3];

  // Frame FSM: walk digits 0..3 in order on accepted dwells, flagging bad anodes and out-of-order digits
  always_comb begin
    state_nxt     = state;
    exp_nxt       = exp_idx;
    stg_nxt       = stg;
    dig_nxt       = dig_q;
    strobe_nxt    = 1'b0;
    valid_nxt     = frame_valid;
    err_anode_nxt = 1'b0;
    err_order_nxt = 1'b0;
    dec           = decode_anode(an_sync);

    if (accept) begin
      if (dec.kind == AN_KIND_ILLEGAL) begin
        // Any error invalidates the "good frame seen" status; the partial frame is dropped
        err_anode_nxt = 1'b1;
        valid_nxt     = 1'b0;
        state_nxt     = ST_IDLE;
      end else if (dec.kind == AN_KIND_DIGIT) begin
        if (state == ST_IDLE) begin
          // Frames only start on digit 0; later digits seen while idle are ignored
          if (dec.idx == 2'd0) begin
            stg_nxt[0] = sseg_sync;
            exp_nxt    = 2'd1;
            state_nxt  = ST_SCAN;
          end
        end else if (dec.idx == exp_idx) begin
          stg_nxt[dec.idx] = sseg_sync;
          if (dec.idx == 2'd3) begin
            // Digit 3 is taken straight from the bus so the frame lands one cycle after acceptance
            dig_nxt    = {sseg_sync, stg[2], stg[1], stg[0]};
            strobe_nxt = 1'b1;
            valid_nxt  = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            exp_nxt = exp_idx + 2'd1;
          end
        end else begin
          err_order_nxt = 1'b1;
          valid_nxt     = 1'b0;
          if (dec.idx == 2'd0) begin
            // A fresh digit 0 is a valid frame start, so resynchronize on it
            stg_nxt[0] = sseg_sync;
            exp_nxt    = 2'd1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
    end
  end

  // State, staging, output and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      exp_idx      <= 2'd1;
      stg          <= {4{SEG_OFF}};
      dig_q        <= {4{SEG_OFF}};
      frame_strobe <= 1'b0;
      frame_valid  <= 1'b0;
      err_anode    <= 1'b0;
      err_order    <= 1'b0;
    end else begin
      state        <= state_nxt;
      exp_idx      <= exp_nxt;
      stg          <= stg_nxt;
      dig_q        <= dig_nxt;
      frame_strobe <= strobe_nxt;
      frame_valid  <= valid_nxt;
      err_anode    <= err_anode_nxt;
      err_order    <= err_order_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Bench for sseg_scan_capture: two instances (SETTLE=2 and SETTLE=3) share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_sseg_scan_capture;

  localparam logic [11:0] RST_SMP = 12'hFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an = 4'hF;
  logic [7:0] sseg = 8'hFF;

  logic [7:0] a_dig0, a_dig1, a_dig2, a_dig3, b_dig0, b_dig1, b_dig2, b_dig3;
  logic       a_strobe, a_valid, a_erra, a_erro, b_strobe, b_valid, b_erra, b_erro;
  logic [35:0] obs_a, obs_b;

  int n_checks = 0;
  int n_fail = 0;

  sseg_scan_capture #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .an(an), .sseg(sseg),
    .dig0(a_dig0), .dig1(a_dig1), .dig2(a_dig2), .dig3(a_dig3),
    .frame_strobe(a_strobe), .frame_valid(a_valid), .err_anode(a_erra), .err_order(a_erro));

  sseg_scan_capture #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .an(an), .sseg(sseg),
    .dig0(b_dig0), .dig1(b_dig1), .dig2(b_dig2), .dig3(b_dig3),
    .frame_strobe(b_strobe), .frame_valid(b_valid), .err_anode(b_erra), .err_order(b_erro));

  assign obs_a = {a_dig0, a_dig1, a_dig2, a_dig3, a_strobe, a_valid, a_erra, a_erro};
  assign obs_b = {b_dig0, b_dig1, b_dig2, b_dig3, b_strobe, b_valid, b_erra, b_erro};

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [35:0] obs_of(input int i);
    return (i == 0) ? obs_a : obs_b;
  endfunction

  // ---------------- reference model ----------------
  // Per instance: a 2-sample delay for the synchronizer, a history of delayed samples,
  // and a list of digits collected so far in the current frame.
  logic [11:0] dly  [2][2];
  logic [11:0] hist [2][32];
  int          hlen [2];
  logic        pend [2];
  logic [11:0] pend_v [2];
  logic [7:0]  col  [2][4];
  int          ncol [2];
  logic [7:0]  m_dig [2][4];
  logic        m_strobe [2], m_valid [2], m_erra [2], m_erro [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int idx_of(input logic [3:0] a);
    for (int k = 0; k < 4; k++) if (a == ~(4'b0001 << k)) return k;
    return (a == 4'hF) ? -1 : -2;   // -1 blank, -2 illegal
  endfunction

  task automatic model_reset(input int i);
    dly[i][0] = RST_SMP; dly[i][1] = RST_SMP;
    hlen[i] = 0; pend[i] = 1'b0; ncol[i] = 0;
    for (int k = 0; k < 4; k++) m_dig[i][k] = 8'hFF;
    m_strobe[i] = 1'b0; m_valid[i] = 1'b0; m_erra[i] = 1'b0; m_erro[i] = 1'b0;
  endtask

  task automatic model_apply(input int i, input logic [11:0] v);
    int idx;
    idx = idx_of(v[11:8]);
    if (idx == -2) begin
      m_erra[i] = 1'b1; m_valid[i] = 1'b0; ncol[i] = 0;
    end else if (idx >= 0) begin
      if (ncol[i] == 0) begin
        if (idx == 0) begin col[i][0] = v[7:0]; ncol[i] = 1; end
      end else if (idx == ncol[i]) begin
        col[i][idx] = v[7:0];
        ncol[i]++;
        if (ncol[i] == 4) begin
          for (int k = 0; k < 4; k++) m_dig[i][k] = col[i][k];
          m_strobe[i] = 1'b1; m_valid[i] = 1'b1; ncol[i] = 0;
        end
      end else begin
        m_erro[i] = 1'b1; m_valid[i] = 1'b0;
        if (idx == 0) begin col[i][0] = v[7:0]; ncol[i] = 1; end
        else ncol[i] = 0;
      end
    end
  endtask

  task automatic model_step(input int i, input logic [11:0] x);
    logic [11:0] smp;
    int run;
    m_strobe[i] = 1'b0; m_erra[i] = 1'b0; m_erro[i] = 1'b0;
    if (pend[i]) model_apply(i, pend_v[i]);
    smp = dly[i][1];
    dly[i][1] = dly[i][0];
    dly[i][0] = x;
    for (int k = 31; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = smp;
    if (hlen[i] < 32) hlen[i]++;
    run = 0;
    for (int k = 0; k < hlen[i]; k++) begin
      if (hist[i][k] != smp) break;
      run++;
    end
    pend[i] = (run == settle_of(i));
    pend_v[i] = smp;
  endtask

  function automatic logic [35:0] model_vec(input int i);
    return {m_dig[i][0], m_dig[i][1], m_dig[i][2], m_dig[i][3],
            m_strobe[i], m_valid[i], m_erra[i], m_erro[i]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else model_step(i, {an, sseg});
    end
  end

  // Cycle-by-cycle comparison against the model, plus pulse counters for the directed table
  int cs [2], ca [2], co [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cycle_dut%0d", i), 64'(obs_of(i)), 64'(model_vec(i)));
    end
    if (a_strobe) cs[0]++;
    if (a_erra)   ca[0]++;
    if (a_erro)   co[0]++;
    if (b_strobe) cs[1]++;
    if (b_erra)   ca[1]++;
    if (b_erro)   co[1]++;
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    sseg = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  sseg;
    int          n_strobe;
    int          n_erra;
    int          n_erro;
    logic        valid;
    logic [31:0] dig;      // {dig0, dig1, dig2, dig3}
  } step_t;

  step_t tbl [32];

  task automatic set_step(input int k, input logic [3:0] a, input logic [7:0] s,
                          input int ns, input int na, input int no,
                          input logic v, input logic [31:0] d);
    tbl[k].an = a; tbl[k].sseg = s; tbl[k].n_strobe = ns; tbl[k].n_erra = na;
    tbl[k].n_erro = no; tbl[k].valid = v; tbl[k].dig = d;
  endtask

  int s0 [2], a0 [2], o0 [2];
  logic [35:0] ov;
  logic [3:0] ra;
  logic [7:0] rs;
  int nd;
  int rsel;

  initial begin
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      cs[i] = 0; ca[i] = 0; co[i] = 0;
    end

    // in-order frame
    set_step(0,  4'hE, 8'hC0, 0, 0, 0, 1'b0, 32'hFFFFFFFF);
    set_step(1,  4'hD, 8'hF9, 0, 0, 0, 1'b0, 32'hFFFFFFFF);
    set_step(2,  4'hB, 8'h24, 0, 0, 0, 1'b0, 32'hFFFFFFFF);
    set_step(3,  4'h7, 8'h30, 1, 0, 0, 1'b1, 32'hC0F92430);
    // frame with blanks between digits
    set_step(4,  4'hE, 8'h88, 0, 0, 0, 1'b1, 32'hC0F92430);
    set_step(5,  4'hF, 8'hFF, 0, 0, 0, 1'b1, 32'hC0F92430);
    set_step(6,  4'hD, 8'h80, 0, 0, 0, 1'b1, 32'hC0F92430);
    set_step(7,  4'hF, 8'hFF, 0, 0, 0, 1'b1, 32'hC0F92430);
    set_step(8,  4'hB, 8'hA4, 0, 0, 0, 1'b1, 32'hC0F92430);
    set_step(9,  4'hF, 8'hFF, 0, 0, 0, 1'b1, 32'hC0F92430);
    set_step(10, 4'h7, 8'hB0, 1, 0, 0, 1'b1, 32'h8880A4B0);
    // illegal anode mid-frame, digit 2 then ignored while idle, then a clean frame
    set_step(11, 4'hE, 8'h11, 0, 0, 0, 1'b1, 32'h8880A4B0);
    set_step(12, 4'hD, 8'h22, 0, 0, 0, 1'b1, 32'h8880A4B0);
    set_step(13, 4'hC, 8'h22, 0, 1, 0, 1'b0, 32'h8880A4B0);
    set_step(14, 4'hB, 8'h33, 0, 0, 0, 1'b0, 32'h8880A4B0);
    set_step(15, 4'hE, 8'h44, 0, 0, 0, 1'b0, 32'h8880A4B0);
    set_step(16, 4'hD, 8'h55, 0, 0, 0, 1'b0, 32'h8880A4B0);
    set_step(17, 4'hB, 8'h66, 0, 0, 0, 1'b0, 32'h8880A4B0);
    set_step(18, 4'h7, 8'h77, 1, 0, 0, 1'b1, 32'h44556677);
    // skipped digit 1 -> order error, go idle
    set_step(19, 4'hE, 8'h01, 0, 0, 0, 1'b1, 32'h44556677);
    set_step(20, 4'hB, 8'h02, 0, 0, 1, 1'b0, 32'h44556677);
    set_step(21, 4'hE, 8'h03, 0, 0, 0, 1'b0, 32'h44556677);
    set_step(22, 4'hD, 8'h04, 0, 0, 0, 1'b0, 32'h44556677);
    set_step(23, 4'hB, 8'h05, 0, 0, 0, 1'b0, 32'h44556677);
    set_step(24, 4'h7, 8'h06, 1, 0, 0, 1'b1, 32'h03040506);
    // early digit 0 -> order error that restarts the frame on the new digit 0
    set_step(25, 4'hE, 8'h07, 0, 0, 0, 1'b1, 32'h03040506);
    set_step(26, 4'hD, 8'h08, 0, 0, 0, 1'b1, 32'h03040506);
    set_step(27, 4'hE, 8'h09, 0, 0, 1, 1'b0, 32'h03040506);
    set_step(28, 4'hD, 8'h0A, 0, 0, 0, 1'b0, 32'h03040506);
    set_step(29, 4'hB, 8'h0B, 0, 0, 0, 1'b0, 32'h03040506);
    set_step(30, 4'h7, 8'h0C, 1, 0, 0, 1'b1, 32'h090A0B0C);
    // digit 3 while idle is silently ignored
    set_step(31, 4'h7, 8'h0D, 0, 0, 0, 1'b1, 32'h090A0B0C);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dut2", 64'(obs_a), 64'({32'hFFFFFFFF, 4'b0000}));
    check("reset_dut3", 64'(obs_b), 64'({32'hFFFFFFFF, 4'b0000}));
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold(4'hF, 8'hFF, 4);

    // directed table, same expectations for both SETTLE values
    for (int k = 0; k < 32; k++) begin
      for (int i = 0; i < 2; i++) begin s0[i] = cs[i]; a0[i] = ca[i]; o0[i] = co[i]; end
      hold(tbl[k].an, tbl[k].sseg, 8);
      for (int i = 0; i < 2; i++) begin
        ov = obs_of(i);
        check($sformatf("step%0d_strobes_dut%0d", k, i), 64'(cs[i] - s0[i]), 64'(tbl[k].n_strobe));
        check($sformatf("step%0d_erranode_dut%0d", k, i), 64'(ca[i] - a0[i]), 64'(tbl[k].n_erra));
        check($sformatf("step%0d_errorder_dut%0d", k, i), 64'(co[i] - o0[i]), 64'(tbl[k].n_erro));
        check($sformatf("step%0d_valid_dut%0d", k, i), 64'(ov[2]), 64'(tbl[k].valid));
        check($sformatf("step%0d_dig_dut%0d", k, i), 64'(ov[35:4]), 64'(tbl[k].dig));
      end
    end

    // toggling segments, then digit 0 held only 2 samples: SETTLE=2 captures, SETTLE=3 does not
    hold(4'hF, 8'hFF, 8);
    for (int i = 0; i < 2; i++) s0[i] = cs[i];
    for (int j = 0; j < 10; j++) hold(4'hE, (j % 2 == 0) ? 8'h12 : 8'h34, 1);
    hold(4'hE, 8'h56, 2);
    hold(4'hD, 8'h57, 8);
    hold(4'hB, 8'h58, 8);
    hold(4'h7, 8'h59, 8);
    check("short_hold_strobes_dut2", 64'(cs[0] - s0[0]), 64'd1);
    check("short_hold_strobes_dut3", 64'(cs[1] - s0[1]), 64'd0);
    check("short_hold_dig_dut2", 64'(obs_a[35:4]), 64'(32'h56575859));
    check("short_hold_dig_dut3", 64'(obs_b[35:4]), 64'(32'h090A0B0C));

    // same toggling, digit 0 now held exactly 3 samples: both capture
    hold(4'hF, 8'hFF, 8);
    for (int i = 0; i < 2; i++) s0[i] = cs[i];
    for (int j = 0; j < 6; j++) hold(4'hE, (j % 2 == 0) ? 8'h12 : 8'h34, 1);
    hold(4'hE, 8'h56, 3);
    hold(4'hD, 8'h5A, 8);
    hold(4'hB, 8'h5B, 8);
    hold(4'h7, 8'h5C, 8);
    check("hold3_strobes_dut3", 64'(cs[1] - s0[1]), 64'd1);
    check("hold3_dig_dut3", 64'(obs_b[35:4]), 64'(32'h565A5B5C));

    // reset for one cycle after digit 2 is captured; partial frame must be discarded
    hold(4'hE, 8'h61, 8);
    hold(4'hD, 8'h62, 8);
    hold(4'hB, 8'h63, 8);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_dut2", 64'(obs_a), 64'({32'hFFFFFFFF, 4'b0000}));
    check("midreset_dut3", 64'(obs_b), 64'({32'hFFFFFFFF, 4'b0000}));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) s0[i] = cs[i];
    hold(4'hB, 8'h63, 4);
    hold(4'h7, 8'h64, 8);
    check("after_reset_no_frame_dut2", 64'(cs[0] - s0[0]), 64'd0);
    check("after_reset_no_frame_dut3", 64'(cs[1] - s0[1]), 64'd0);
    hold(4'hE, 8'h65, 8);
    hold(4'hD, 8'h66, 8);
    hold(4'hB, 8'h67, 8);
    hold(4'h7, 8'h68, 8);
    check("after_reset_dig_dut2", 64'(obs_a[35:4]), 64'(32'h65666768));
    check("after_reset_valid_dut3", 64'(obs_b[2]), 64'd1);

    // randomized dwells, checked every cycle against the model
    nd = 0; ra = 4'hF; rs = 8'hFF;
    for (int k = 0; k < 300; k++) begin
      rsel = int'($urandom_range(0, 9));
      if (rsel <= 5) begin
        ra = ~(4'b0001 << nd); nd = (nd + 1) % 4; rs = 8'($urandom);
      end else if (rsel == 6) begin
        ra = 4'hF; rs = 8'($urandom);
      end else if (rsel == 7) begin
        ra = ~(4'b0001 << $urandom_range(0, 3)); rs = 8'($urandom);
      end else if (rsel == 8) begin
        ra = 4'($urandom_range(0, 15)); rs = 8'($urandom);
      end
      hold(ra, rs, int'($urandom_range(1, 6)));
    end
    hold(4'hF, 8'hFF, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
